mem_port_arbiter: RTL and testbench

Shares one single-port, 64-bit-wide synchronous SRAM between the core's instruction-fetch port and load/store port, so program and data can live in one unified memory.
- Load/store has fixed priority.
- An aging counter guarantees fetch progress when both requesters are busy.
- Read data is routed back one cycle after grant, matching the SRAM's one-cycle read latency.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_arb_age_cnt.sv | 31 +++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the unified-memory port arbiter.
`default_nettype none

package mem_arb_pkg;

  localparam int IF_IDX     = 0;
  localparam int LS_IDX     = 1;
  localparam int WAIT_CNT_W = 4;

  // One-hot {ls, if}: which requester owns the read data returning next cycle
  typedef logic [1:0] resp_sel_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// Requester and SRAM bus bundle for mem_port_arbiter; names are from the arbiter's view.
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 10
);

  logic                  i_if_req;
  logic [63:0]           i_if_addr;
  logic                  o_if_gnt;
  logic                  o_if_rvalid;
  logic [31:0]           o_if_rdata;

  logic                  i_ls_req;
  logic                  i_ls_we;
  logic [63:0]           i_ls_addr;
  logic [63:0]           i_ls_wdata;
  logic                  o_ls_gnt;
  logic                  o_ls_rvalid;
  logic [63:0]           o_ls_rdata;

  logic                  o_mem_cs;
  logic                  o_mem_we;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [63:0]           o_mem_wdata;
  logic [63:0]           i_mem_rdata;

  modport slave (
    input  i_if_req, i_if_addr, i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_mem_rdata,
    output o_if_gnt, o_if_rvalid, o_if_rdata, o_ls_gnt, o_ls_rvalid, o_ls_rdata,
           o_mem_cs, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_if_req, i_if_addr, i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_mem_rdata,
    input  o_if_gnt, o_if_rvalid, o_if_rdata, o_ls_gnt, o_ls_rvalid, o_ls_rdata,
           o_mem_cs, o_mem_we, o_mem_addr, o_mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/mem_arb_age_cnt.sv
// Saturating count of consecutive denied request cycles; expired once the limit is reached.
`default_nettype none

module mem_arb_age_cnt
  import mem_arb_pkg::*;
(
  input  wire logic                  i_clk,
  input  wire logic                  i_rst_n,
  input  wire logic                  i_req,
  input  wire logic                  i_gnt,
  input  wire logic [WAIT_CNT_W-1:0] i_limit,
  output logic                       o_expired
);

  logic [WAIT_CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      r_cnt <= '0;
    end else if (r_cnt < i_limit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == i_limit);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store onto one 64-bit single-port SRAM; ls has priority, aged fetch overrides.
// Optional MEM_ARB_PERF_EN adds grant and fetch-stall counters.
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WAIT   = 3
) (
  input  wire logic          i_clk,
  input  wire logic          i_rst_n,
  mem_port_arbiter_if.slave  bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]        o_if_gnt_cnt,
  output logic [31:0]        o_ls_gnt_cnt,
  output logic [31:0]        o_if_stall_cnt
`endif
);

  localparam logic [WAIT_CNT_W-1:0] c_max_wait = WAIT_CNT_W'(MAX_WAIT);

  logic      w_expired;
  logic      w_if_gnt;
  logic      w_ls_gnt;
  resp_sel_t r_resp_sel;
  logic      r_if_half;

  mem_arb_age_cnt u_age_cnt (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (bus.i_if_req),
    .i_gnt     (w_if_gnt),
    .i_limit   (c_max_wait),
    .o_expired (w_expired)
  );

  // Grants are gated by reset so nothing reaches the SRAM while it is held
  always_comb begin
    w_if_gnt = 1'b0;
    w_ls_gnt = 1'b0;
    if (i_rst_n) begin
      if (bus.i_if_req && (!bus.i_ls_req || w_expired)) begin
        w_if_gnt = 1'b1;
      end else if (bus.i_ls_req) begin
        w_ls_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    bus.o_mem_cs    = 1'b0;
    bus.o_mem_we    = 1'b0;
    bus.o_mem_addr  = '0;
    bus.o_mem_wdata = '0;
    if (w_if_gnt) begin
      bus.o_mem_cs   = 1'b1;
      bus.o_mem_addr = bus.i_if_addr[ADDR_WIDTH+2:3];
    end else if (w_ls_gnt) begin
      bus.o_mem_cs    = 1'b1;
      bus.o_mem_we    = bus.i_ls_we;
      bus.o_mem_addr  = bus.i_ls_addr[ADDR_WIDTH+2:3];
      bus.o_mem_wdata = bus.i_ls_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_resp_sel <= '0;
      r_if_half  <= 1'b0;
    end else begin
      r_resp_sel[IF_IDX] <= w_if_gnt;
      r_resp_sel[LS_IDX] <= w_ls_gnt && !bus.i_ls_we;
      if (w_if_gnt) begin
        r_if_half <= bus.i_if_addr[2];
      end
    end
  end

  assign bus.o_if_gnt    = w_if_gnt;
  assign bus.o_ls_gnt    = w_ls_gnt;
  assign bus.o_if_rvalid = r_resp_sel[IF_IDX];
  assign bus.o_ls_rvalid = r_resp_sel[LS_IDX];
  assign bus.o_if_rdata  = !r_resp_sel[IF_IDX] ? 32'd0 :
                           (r_if_half ? bus.i_mem_rdata[63:32] : bus.i_mem_rdata[31:0]);
  assign bus.o_ls_rdata  = r_resp_sel[LS_IDX] ? bus.i_mem_rdata : 64'd0;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_if_gnt_cnt;
  logic [31:0] r_ls_gnt_cnt;
  logic [31:0] r_if_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_if_gnt_cnt   <= '0;
      r_ls_gnt_cnt   <= '0;
      r_if_stall_cnt <= '0;
    end else begin
      if (w_if_gnt)                     r_if_gnt_cnt   <= r_if_gnt_cnt + 32'd1;
      if (w_ls_gnt)                     r_ls_gnt_cnt   <= r_ls_gnt_cnt + 32'd1;
      if (bus.i_if_req && !w_if_gnt)    r_if_stall_cnt <= r_if_stall_cnt + 32'd1;
    end
  end

  assign o_if_gnt_cnt   = r_if_gnt_cnt;
  assign o_ls_gnt_cnt   = r_ls_gnt_cnt;
  assign o_if_stall_cnt = r_if_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural one-cycle-latency SRAM.
`default_nettype none

module tb_mem_port_arbiter;

  localparam int ADDR_WIDTH = 10;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [63:0] mem [0:(1<<ADDR_WIDTH)-1];

`ifdef MEM_ARB_PERF_EN
  logic [31:0] if_gnt_cnt;
  logic [31:0] ls_gnt_cnt;
  logic [31:0] if_stall_cnt;
`endif

  mem_port_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAX_WAIT   (3)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .bus            (bus.slave)
`ifdef MEM_ARB_PERF_EN
    ,
    .o_if_gnt_cnt   (if_gnt_cnt),
    .o_ls_gnt_cnt   (ls_gnt_cnt),
    .o_if_stall_cnt (if_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.o_mem_cs) begin
      if (bus.o_mem_we) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
      else              bus.i_mem_rdata     <= mem[bus.o_mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] c_w5  = 64'hAAAA_BBBB_1111_2222;
  localparam logic [63:0] c_w8  = 64'hDEAD_BEEF_0123_4567;
  localparam logic [7:0]  c_seq = 8'b1000_1000;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n          = 1'b0;
    bus.i_if_req   = 1'b1;
    bus.i_if_addr  = 64'd0;
    bus.i_ls_req   = 1'b1;
    bus.i_ls_we    = 1'b0;
    bus.i_ls_addr  = 64'd0;
    bus.i_ls_wdata = 64'd0;

    // Reset held with both requests active
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_if_gnt", 64'(bus.o_if_gnt), 64'd0);
    check_eq("rst_ls_gnt", 64'(bus.o_ls_gnt), 64'd0);
    check_eq("rst_mem_cs", 64'(bus.o_mem_cs), 64'd0);
    check_eq("rst_mem_we", 64'(bus.o_mem_we), 64'd0);
    check_eq("rst_if_rvalid", 64'(bus.o_if_rvalid), 64'd0);
    check_eq("rst_ls_rvalid", 64'(bus.o_ls_rvalid), 64'd0);
    rst_n = 1'b1;
    #1;
    check_eq("rel_ls_gnt", 64'(bus.o_ls_gnt), 64'd1);
    check_eq("rel_if_gnt", 64'(bus.o_if_gnt), 64'd0);
    check_eq("rel_mem_cs", 64'(bus.o_mem_cs), 64'd1);
    step();
    bus.i_if_req = 1'b0;
    bus.i_ls_req = 1'b0;
    #1;
    check_eq("rel_ls_rvalid", 64'(bus.o_ls_rvalid), 64'd1);
    check_eq("rel_if_rvalid", 64'(bus.o_if_rvalid), 64'd0);

    // Fetch only: store word 5 first, then fetch both halves
    bus.i_ls_req   = 1'b1;
    bus.i_ls_we    = 1'b1;
    bus.i_ls_addr  = 64'h28;
    bus.i_ls_wdata = c_w5;
    #1;
    check_eq("st5_mem_we", 64'(bus.o_mem_we), 64'd1);
    check_eq("st5_mem_addr", 64'(bus.o_mem_addr), 64'd5);
    step();
    bus.i_ls_req  = 1'b0;
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 64'h28;
    #1;
    check_eq("st5_no_rvalid", 64'(bus.o_ls_rvalid), 64'd0);
    check_eq("if28_gnt", 64'(bus.o_if_gnt), 64'd1);
    check_eq("if28_mem_we", 64'(bus.o_mem_we), 64'd0);
    check_eq("if28_mem_addr", 64'(bus.o_mem_addr), 64'd5);
    step();
    bus.i_if_addr = 64'h2C;
    #1;
    check_eq("if28_rvalid", 64'(bus.o_if_rvalid), 64'd1);
    check_eq("if28_rdata", 64'(bus.o_if_rdata), 64'h1111_2222);
    check_eq("if2c_gnt", 64'(bus.o_if_gnt), 64'd1);
    step();
    bus.i_if_req = 1'b0;
    #1;
    check_eq("if2c_rvalid", 64'(bus.o_if_rvalid), 64'd1);
    check_eq("if2c_rdata", 64'(bus.o_if_rdata), 64'hAAAA_BBBB);
    check_eq("if2c_ls_rdata_zero", bus.o_ls_rdata, 64'd0);

    // Store then load word 8
    step();
    bus.i_ls_req   = 1'b1;
    bus.i_ls_we    = 1'b1;
    bus.i_ls_addr  = 64'h40;
    bus.i_ls_wdata = c_w8;
    #1;
    check_eq("st8_mem_we", 64'(bus.o_mem_we), 64'd1);
    check_eq("st8_mem_addr", 64'(bus.o_mem_addr), 64'd8);
    check_eq("st8_mem_wdata", bus.o_mem_wdata, c_w8);
    step();
    bus.i_ls_we = 1'b0;
    #1;
    check_eq("st8_no_rvalid", 64'(bus.o_ls_rvalid), 64'd0);
    check_eq("ld8_mem_we", 64'(bus.o_mem_we), 64'd0);
    step();
    bus.i_ls_req = 1'b0;
    #1;
    check_eq("ld8_rvalid", 64'(bus.o_ls_rvalid), 64'd1);
    check_eq("ld8_rdata", bus.o_ls_rdata, c_w8);
    check_eq("idle_mem_cs", 64'(bus.o_mem_cs), 64'd0);
    check_eq("idle_mem_addr", 64'(bus.o_mem_addr), 64'd0);

    // High address bits are ignored and wrap onto word 8
    step();
    bus.i_ls_req  = 1'b1;
    bus.i_ls_addr = 64'h1000_0000_0000_2040;
    #1;
    check_eq("wrap_mem_addr", 64'(bus.o_mem_addr), 64'd8);
    step();
    bus.i_ls_req = 1'b0;
    #1;
    check_eq("wrap_rdata", bus.o_ls_rdata, c_w8);

    // Reset while a load response is in flight
    step();
    bus.i_ls_req  = 1'b1;
    bus.i_ls_we   = 1'b0;
    bus.i_ls_addr = 64'h40;
    #1;
    check_eq("midrst_ls_gnt", 64'(bus.o_ls_gnt), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_gnt_forced", 64'(bus.o_ls_gnt), 64'd0);
    check_eq("midrst_cs_forced", 64'(bus.o_mem_cs), 64'd0);
    bus.i_ls_req = 1'b0;
    step();
    check_eq("midrst_rvalid_held", 64'(bus.o_ls_rvalid), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("midrst_rvalid_after", 64'(bus.o_ls_rvalid), 64'd0);
    end
`ifdef MEM_ARB_PERF_EN
    check_eq("perf_rst_if", 64'(if_gnt_cnt), 64'd0);
    check_eq("perf_rst_ls", 64'(ls_gnt_cnt), 64'd0);
`endif

    // Contention: aging lets fetch through every fourth cycle
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 64'h28;
    bus.i_ls_req  = 1'b1;
    bus.i_ls_addr = 64'h40;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq("cont_if_gnt", 64'(bus.o_if_gnt), 64'(c_seq[i]));
      check_eq("cont_ls_gnt", 64'(bus.o_ls_gnt), 64'(!c_seq[i]));
      if (i > 0) begin
        check_eq("cont_if_rvalid", 64'(bus.o_if_rvalid), 64'(c_seq[i-1]));
        check_eq("cont_ls_rvalid", 64'(bus.o_ls_rvalid), 64'(!c_seq[i-1]));
        if (c_seq[i-1]) check_eq("cont_if_rdata", 64'(bus.o_if_rdata), 64'h1111_2222);
        else            check_eq("cont_ls_rdata", bus.o_ls_rdata, c_w8);
      end
      step();
    end
    bus.i_if_req = 1'b0;
    bus.i_ls_req = 1'b0;
    #1;
    check_eq("cont_last_if_rvalid", 64'(bus.o_if_rvalid), 64'd1);
    check_eq("cont_last_ls_rvalid", 64'(bus.o_ls_rvalid), 64'd0);
    check_eq("cont_last_if_rdata", 64'(bus.o_if_rdata), 64'h1111_2222);
`ifdef MEM_ARB_PERF_EN
    check_eq("perf_if_gnt_cnt", 64'(if_gnt_cnt), 64'd2);
    check_eq("perf_ls_gnt_cnt", 64'(ls_gnt_cnt), 64'd6);
    check_eq("perf_if_stall_cnt", 64'(if_stall_cnt), 64'd6);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
